// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcodes, ALU function codes, sequencer state encoding
//                and small decode helpers for the 18-bit processor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction word width
    localparam int IW = 18;

    // Opcodes, IR[17:14]
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_ANDI = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_JUMP = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_BLT  = 4'hB;
    localparam logic [3:0] OP_BGE  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    // ALU function codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ALU function for an opcode; loads/stores use ADD for address forming
    function automatic logic [2:0] alu_op_of(input logic [3:0] opcode);
        case (opcode)
            OP_AND, OP_ANDI: alu_op_of = ALU_AND;
            OP_NAND:         alu_op_of = ALU_NAND;
            OP_NOR:          alu_op_of = ALU_NOR;
            default:         alu_op_of = ALU_ADD;
        endcase
    endfunction

    // Immediate second operand for the I-form ALU instructions
    function automatic logic uses_imm(input logic [3:0] opcode);
        uses_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond
//  Description : Combinational branch-taken evaluation from opcode and the
//                registered ALU zero/negative flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import cpu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_flag_z,
    input  logic           i_flag_n,
    output logic           o_taken
);

    // Non-branch opcodes report not-taken
    always_comb begin
        o_taken = 1'b0;
        case (i_opcode)
            OP_BEQ:  o_taken = i_flag_z;
            OP_BNE:  o_taken = !i_flag_z;
            OP_BLT:  o_taken = i_flag_n;
            OP_BGE:  o_taken = !i_flag_n;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM control FSM. Owns the
//                instruction register and drives the program-counter controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW = 4,
    parameter int AW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] instr_in,
    output logic          imem_req,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ack,
    input  logic          flag_z,
    input  logic          flag_n,
    output logic          pc_enable,
    output logic          pc_next,
    output logic          pc_is_jump,
    output logic [AW-1:0] pc_offset,
    output logic [IW-1:0] ir,
    output logic          reg_we,
    output logic          alu_src_imm,
    output logic          mem_to_reg,
    output logic [2:0]    alu_op,
    output logic          halted,
    output logic          illegal
);

    state_t          r_state;
    logic [IW-1:0]   r_ir;
    logic            r_imem_req;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic [2:0]      r_alu_op;
    logic            r_alu_src_imm;
    logic            r_mem_to_reg;
    logic            r_halted;

    logic [OPW-1:0]  w_opcode;
    logic            w_taken;
    logic            w_reg_we;
    logic            w_advance;
    logic            w_jump;
    logic            w_illegal;

    assign w_opcode = r_ir[IW-1 -: OPW];

    branch_cond #(
        .OPW      (OPW)
    ) u_branch_cond (
        .i_opcode (w_opcode),
        .i_flag_z (flag_z),
        .i_flag_n (flag_n),
        .o_taken  (w_taken)
    );

    // Main sequencer: state, IR, handshake requests and decoded datapath controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            r_imem_req    <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_alu_op      <= ALU_ADD;
            r_alu_src_imm <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Request is already high on entry; it stays put until ack
                    if (imem_ack) begin
                        r_ir       <= instr_in;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_alu_op      <= alu_op_of(w_opcode);
                    r_alu_src_imm <= uses_imm(w_opcode);
                    r_mem_to_reg  <= (w_opcode == OP_LD);
                    r_state       <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_opcode == OP_LD || w_opcode == OP_ST) begin
                        r_state    <= S_MEM;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (w_opcode == OP_ST);
                    end else if (w_opcode == OP_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Single-cycle EXEC / MEM-ack strobes, decoded from the registered state and
    // IR so that flags are sampled in EXEC and the load write-back lines up
    // with dmem_ack in the same cycle
    always_comb begin
        w_reg_we  = 1'b0;
        w_advance = 1'b0;
        w_jump    = 1'b0;
        w_illegal = 1'b0;
        if (r_state == S_EXEC) begin
            case (w_opcode)
                OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_NAND, OP_NOR: begin
                    w_reg_we  = 1'b1;
                    w_advance = 1'b1;
                end
                OP_LD, OP_ST, OP_HALT: begin
                    w_advance = 1'b0;
                end
                OP_JUMP: begin
                    w_jump = 1'b1;
                end
                OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
                    w_jump    = w_taken;
                    w_advance = !w_taken;
                end
                default: begin
                    w_illegal = 1'b1;
                    w_advance = 1'b1;
                end
            endcase
        end else if (r_state == S_MEM && dmem_ack) begin
            w_advance = 1'b1;
            w_reg_we  = (w_opcode == OP_LD);
        end
    end

    assign imem_req    = r_imem_req;
    assign dmem_req    = r_dmem_req;
    assign dmem_we     = r_dmem_we;
    assign pc_enable   = w_advance;
    assign pc_next     = w_advance;
    assign pc_is_jump  = w_jump;
    assign pc_offset   = r_ir[AW-1:0];
    assign ir          = r_ir;
    assign reg_we      = w_reg_we;
    assign alu_src_imm = r_alu_src_imm;
    assign mem_to_reg  = r_mem_to_reg;
    assign alu_op      = r_alu_op;
    assign halted      = r_halted;
    assign illegal     = w_illegal;

endmodule
`default_nettype wire
